brlshft_seq: RTL and testbench

Multi-pass sequencer that sits directly upstream of the 4-bit combinational barrel shifter (`brlshft`) and feeds it. It accepts one shift command per handshake with a total shift amount of up to 15. It then drives the shifter's `l_r`, `rot`, `sv1`/`sv0` and `in` ports over as many clock cycles as needed, stepping at most 3 positions per cycle. Each cycle it feeds the shifter's `out` back into its data register. The final value is registered on `dout`, and `done` pulses for one cycle.

---
 rtl/brlshft_seq.sv | 94 +++++++++
 tb/tb_brlshft_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/brlshft_seq.sv
// rtl/brlshft_seq.sv - multi-pass sequencer driving an external 4-bit barrel shifter, at most 3 positions per cycle
// Optional feature macro: BRLSHFT_SEQ_ROTMOD_EN (rotates reduce the amount mod 4 on accept).
module brlshft_seq #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic             rot_in,
  input  logic [AMT_W-1:0] amt,
  input  logic [3:0]       din,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dout,
  output logic             l_r,
  output logic             rot,
  output logic             sv1,
  output logic             sv0,
  output logic [3:0]       sh_in,
  input  logic [3:0]       sh_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [3:0]       data;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] rem_nx;
  logic [AMT_W-1:0] amt_eff;
  logic [1:0]       step;
  logic             accept;
  logic             last;

  assign accept = start && (state != RUN);
  assign rem_nx = rem - AMT_W'(step);
  assign last   = (rem_nx == '0);
  assign sh_in  = data;

  always_comb begin
    step = 2'd3;
    if (rem < AMT_W'(3)) step = rem[1:0];
  end

`ifdef BRLSHFT_SEQ_ROTMOD_EN
  // A full rotation is the identity, so only amt mod 4 matters for rotates.
  assign amt_eff = rot_in ? (amt & AMT_W'(3)) : amt;
`else
  assign amt_eff = amt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN);
    done       = (state == DONE);
    {sv1, sv0} = (state == RUN) ? step : 2'b00;
  end

  // The shifter result is folded back into data every RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 4'd0;
      rem  <= '0;
      l_r  <= 1'b0;
      rot  <= 1'b0;
      dout <= 4'd0;
    end else if (accept) begin
      data <= din;
      rem  <= amt_eff;
      l_r  <= dir;
      rot  <= rot_in;
    end else if (state == RUN) begin
      data <= sh_out;
      rem  <= rem_nx;
      if (last) dout <= sh_out;
    end
  end

endmodule

// File: tb/tb_brlshft_seq.sv
// tb/tb_brlshft_seq.sv - table-driven bench for brlshft_seq with a behavioural barrel shifter in the loop
module tb_brlshft_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic       rot_in = 1'b0;
  logic [3:0] amt = 4'd0;
  logic [3:0] din = 4'd0;
  logic       busy, done, l_r, rot, sv1, sv0;
  logic [3:0] dout, sh_in, sh_out;

  int total = 0;
  int bad = 0;

  brlshft_seq #(.AMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .rot_in(rot_in),
    .amt(amt), .din(din), .busy(busy), .done(done), .dout(dout),
    .l_r(l_r), .rot(rot), .sv1(sv1), .sv0(sv0), .sh_in(sh_in), .sh_out(sh_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] shf(input logic [3:0] x, input logic left, input logic r,
                                     input logic [1:0] s);
    logic [7:0] dbl;
    dbl = {x, x};
    if (r) begin
      if (left) shf = 4'((dbl << s) >> 4);
      else      shf = 4'(dbl >> s);
    end else begin
      if (left) shf = x << s;
      else      shf = x >> s;
    end
  endfunction

  always_comb sh_out = shf(sh_in, l_r, rot, {sv1, sv0});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       d;
    logic       r;
    logic [3:0] a;
    logic [3:0] di;
    logic [3:0] res;
    int         n_full;
    int         n_mod;
    logic [9:0] sv_full;
    logic [9:0] sv_mod;
  } vec_t;

  vec_t vt[8];

  // Step values packed first-step-in-low-bits.
  task automatic run_cmd(input logic d, input logic r, input logic [3:0] a, input logic [3:0] di,
                         input bit inject, output int nb, output logic [9:0] svs, output bit ok);
    @(negedge clk);
    dir = d; rot_in = r; amt = a; din = di; start = 1'b1;
    @(negedge clk);
    start = 1'b0; nb = 0; svs = '0; ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy) begin
        if (nb == 0) begin
          chk("sh_in_first", 32'(sh_in), 32'(di));
          chk("l_r_latched", 32'(l_r), 32'(d));
          chk("rot_latched", 32'(rot), 32'(r));
        end
        if (nb < 5) svs = svs | (10'({sv1, sv0}) << (2 * nb));
        nb++;
        if (inject && nb == 1) begin
          start = 1'b1; din = ~di; amt = 4'd0; dir = ~d; rot_in = ~r;
        end else begin
          start = 1'b0;
        end
      end else begin
        start = 1'b0;
        ok = done;
        break;
      end
      @(negedge clk);
    end
  endtask

  int         nb;
  logic [9:0] svs;
  bit         ok;
  int         exp_n;
  logic [9:0] exp_sv;
  int         done_seen;

  initial begin
    vt[0] = '{1'b1, 1'b1, 4'd5,  4'b1011, 4'b0111, 2, 1, 10'h00B, 10'h001};
    vt[1] = '{1'b0, 1'b0, 4'd2,  4'b1100, 4'b0011, 1, 1, 10'h002, 10'h002};
    vt[2] = '{1'b1, 1'b0, 4'd4,  4'b1111, 4'b0000, 2, 2, 10'h007, 10'h007};
    vt[3] = '{1'b0, 1'b0, 4'd0,  4'b1010, 4'b1010, 1, 1, 10'h000, 10'h000};
    vt[4] = '{1'b0, 1'b1, 4'd15, 4'b0110, 4'b1100, 5, 1, 10'h3FF, 10'h003};
    vt[5] = '{1'b1, 1'b0, 4'd7,  4'b0001, 4'b0000, 3, 3, 10'h01F, 10'h01F};
    vt[6] = '{1'b0, 1'b0, 4'd1,  4'b1001, 4'b0100, 1, 1, 10'h001, 10'h001};
    vt[7] = '{1'b1, 1'b1, 4'd6,  4'b1000, 4'b0010, 2, 1, 10'h00F, 10'h002};

    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_lr_rot", 32'({l_r, rot}), 0);
    chk("rst_sv", 32'({sv1, sv0}), 0);
    chk("rst_sh_in", 32'(sh_in), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
`ifdef BRLSHFT_SEQ_ROTMOD_EN
      exp_n = vt[i].n_mod;  exp_sv = vt[i].sv_mod;
`else
      exp_n = vt[i].n_full; exp_sv = vt[i].sv_full;
`endif
      run_cmd(vt[i].d, vt[i].r, vt[i].a, vt[i].di, 1'b0, nb, svs, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 1);
      chk($sformatf("v%0d_run_cycles", i), 32'(nb), 32'(exp_n));
      chk($sformatf("v%0d_sv_seq", i), 32'(svs), 32'(exp_sv));
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vt[i].res));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'({done, busy}), 0);
      chk($sformatf("v%0d_dout_hold", i), 32'(dout), 32'(vt[i].res));
    end

    // Back-to-back: new command issued in the DONE cycle.
    run_cmd(1'b0, 1'b0, 4'd2, 4'b1100, 1'b0, nb, svs, ok);
    chk("b2b_first_done", 32'(ok), 1);
    chk("b2b_first_dout", 32'(dout), 32'(4'b0011));
    dir = 1'b0; rot_in = 1'b1; amt = 4'd1; din = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_sv", 32'({sv1, sv0}), 1);
    @(negedge clk);
    chk("b2b_done", 32'(done), 1);
    chk("b2b_dout", 32'(dout), 32'(4'b1000));

    // start while busy must not disturb the running command.
    run_cmd(1'b0, 1'b1, 4'd9, 4'b0001, 1'b1, nb, svs, ok);
`ifdef BRLSHFT_SEQ_ROTMOD_EN
    exp_n = 1;
`else
    exp_n = 3;
`endif
    chk("inj_done", 32'(ok), 1);
    chk("inj_run_cycles", 32'(nb), 32'(exp_n));
    chk("inj_dout", 32'(dout), 32'(4'b1000));
    @(negedge clk);
    chk("inj_no_rerun", 32'({busy, done}), 0);

    // Asynchronous reset in the second RUN cycle of a long command.
    @(negedge clk);
    dir = 1'b1; rot_in = 1'b0; amt = 4'd15; din = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy1", 32'(busy), 1);
    @(negedge clk);
    chk("mid_busy2", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_lr_rot", 32'({l_r, rot}), 0);
    chk("mid_rst_sv", 32'({sv1, sv0}), 0);
    chk("mid_rst_sh_in", 32'(sh_in), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("mid_no_done", 32'(done_seen), 0);
    chk("mid_dout_after", 32'(dout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
